// File: rtl/uart_rx_if.sv
// uart_rx byte handshake bundle.
// Producer drives data/valid, consumer drives ready.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      clk_in,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      rx_busy,
  output logic      frame_err,
  output logic      overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic      parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t state, state_d;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    sh, sh_d;
  logic [7:0]    data, data_d;
  logic          valid, valid_d;
  logic          ferr, ferr_d;
  logic          ovr, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic          pbad, pbad_d;
  logic          perr, perr_d;
`endif

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM next state plus datapath updates.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    sh_d    = sh;
    data_d  = data;
    valid_d = valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad;
    perr_d  = 1'b0;
`endif

    if (valid && bus.rx_ready)
      valid_d = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s)
          state_d = START;
      end

      START: begin
        if (cnt == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s)
            state_d = IDLE;
          else
            state_d = DATA;
        end
      end

      DATA: begin
        if (cnt == LAST) begin
          cnt_d     = '0;
          sh_d[idx] = rx_s;
          idx_d     = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          pbad_d  = rx_s ^ (^sh);
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (pbad) begin
            perr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else if (valid && !bus.rx_ready) begin
            ovr_d   = 1'b1;
            state_d = IDLE;
          end else begin
            // A same-edge accept is superseded.
            valid_d = 1'b1;
            data_d  = sh;
            state_d = IDLE;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rx_s)
          state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad  <= 1'b0;
      perr  <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
      data  <= data_d;
      valid <= valid_d;
      ferr  <= ferr_d;
      ovr   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad  <= pbad_d;
      perr  <= perr_d;
`endif
    end
  end

  assign bus.rx_data  = data;
  assign bus.rx_valid = valid;
  assign rx_busy      = (state != IDLE);
  assign frame_err    = ferr;
  assign overrun      = ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx.
// Build with UART_RX_PARITY_EN for the 8E1 steps.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk_in;
  logic rst;
  logic rx;
  logic rx_busy;
  logic frame_err;
  logic overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got[$];
  int vcyc  = 0;
  int nferr = 0;
  int novr  = 0;
  int nperr = 0;

  // Passive monitor: accepted bytes and pulse counts.
  always @(negedge clk_in) begin
    if (rst) begin
      if (bus.rx_valid)
        vcyc++;
      if (bus.rx_valid && bus.rx_ready)
        got.push_back(bus.rx_data);
      if (frame_err)
        nferr++;
      if (overrun)
        novr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err)
        nperr++;
`endif
    end
  end

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic bit_t(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk_in);
  endtask

  task automatic send_p(input logic [7:0] b,
                        input logic p,
                        input logic stop_v);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++)
      bit_t(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_t(p);
`else
    if (p) begin end
`endif
    bit_t(stop_v);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop_v);
    send_p(b, ^b, stop_v);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_in);
    #1 bus.rx_ready = v;
  endtask

  int b0, f0, o0, v0, p0;

  initial begin
    rst          = 1'b0;
    rx           = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk_in);

    chk("rst_valid", int'(bus.rx_valid), 0);
    chk("rst_data",  int'(bus.rx_data),  0);
    chk("rst_busy",  int'(rx_busy),      0);
    chk("rst_ferr",  int'(frame_err),    0);
    chk("rst_ovr",   int'(overrun),      0);

    rst = 1'b1;
    idle(8);

    // Single byte
    b0 = got.size();
    v0 = vcyc;
    f0 = nferr;
    send(8'hA5, 1'b1);
    idle(20);
    chk("a5_count", got.size() - b0, 1);
    chk("a5_data",  int'(got[b0]), 'hA5);
    chk("a5_vcyc",  vcyc - v0, 1);
    chk("a5_busy",  int'(rx_busy), 0);
    chk("a5_ferr",  nferr - f0, 0);

    // Back-to-back
    b0 = got.size();
    f0 = nferr;
    o0 = novr;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    idle(20);
    chk("b2b_count", got.size() - b0, 3);
    chk("b2b_0", int'(got[b0]),     'h00);
    chk("b2b_1", int'(got[b0 + 1]), 'hFF);
    chk("b2b_2", int'(got[b0 + 2]), 'h55);
    chk("b2b_err", (nferr - f0) + (novr - o0), 0);

    // Overrun
    set_ready(1'b0);
    b0 = got.size();
    o0 = novr;
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    idle(20);
    chk("ovr_valid", int'(bus.rx_valid), 1);
    chk("ovr_data",  int'(bus.rx_data), 'h12);
    chk("ovr_pulse", novr - o0, 1);
    chk("ovr_noacc", got.size() - b0, 0);
    set_ready(1'b1);
    repeat (3) @(negedge clk_in);
    chk("ovr_clear", int'(bus.rx_valid), 0);
    chk("ovr_acc",   int'(got[got.size() - 1]), 'h12);

    // Glitch
    b0 = got.size();
    f0 = nferr;
    rx = 1'b0;
    repeat (5) @(negedge clk_in);
    idle(30);
    chk("gl_nobyte", got.size() - b0, 0);
    chk("gl_noferr", nferr - f0, 0);
    chk("gl_busy",   int'(rx_busy), 0);

    // Framing error
    v0 = vcyc;
    send(8'h3C, 1'b0);
    idle(20);
    chk("fe_pulse",   nferr - f0, 1);
    chk("fe_novalid", vcyc - v0, 0);

    // Long break then a good byte
    f0 = nferr;
    b0 = got.size();
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk_in);
    idle(CPB);
    send(8'h81, 1'b1);
    idle(20);
    chk("brk_ferr",  nferr - f0, 1);
    chk("brk_count", got.size() - b0, 1);
    chk("brk_data",  int'(got[b0]), 'h81);

    // Reset mid-frame
    b0 = got.size();
    bit_t(1'b0);
    bit_t(1'b0);
    bit_t(1'b0);
    bit_t(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk_in);
    chk("mid_busy", int'(rx_busy), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("mr_valid", int'(bus.rx_valid), 0);
    chk("mr_data",  int'(bus.rx_data),  0);
    chk("mr_busy",  int'(rx_busy),      0);
    chk("mr_ferr",  int'(frame_err),    0);
    chk("mr_ovr",   int'(overrun),      0);
    rx = 1'b1;
    @(negedge clk_in);
    rst = 1'b1;
    idle(CPB);
    send(8'h0F, 1'b1);
    idle(20);
    chk("mr_count", got.size() - b0, 1);
    chk("mr_byte",  int'(got[b0]), 'h0F);

`ifdef UART_RX_PARITY_EN
    // Even parity
    b0 = got.size();
    p0 = nperr;
    send_p(8'h07, 1'b1, 1'b1);
    idle(20);
    chk("par_ok_cnt",  got.size() - b0, 1);
    chk("par_ok_data", int'(got[b0]), 'h07);
    chk("par_ok_err",  nperr - p0, 0);
    v0 = vcyc;
    send_p(8'h07, 1'b0, 1'b1);
    idle(20);
    chk("par_bad_err",   nperr - p0, 1);
    chk("par_bad_valid", vcyc - v0, 0);
`else
    p0 = nperr;
    chk("no_perr", p0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
